g9_led_display: RTL and testbench

Display-side consumer of the processor's 32-bit `led_output` word: samples it, detects changes, and time-multiplexes it as eight hexadecimal digits onto a common-anode seven-segment display. It sits at the board top level between `G9Processor` and the FPGA pins. It performs the observing role the simulation fixture plays in simulation.

---
 rtl/g9_led_display.sv | 102 ++++++++++
 tb/tb_g9_led_display.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/g9_led_display.sv
// g9_led_display: samples the processor's led_output word, flags changes, and
// scans it as eight hex digits onto a common-anode seven-segment display.
module g9_led_display #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] led_output,
    input  logic        freeze,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic        dp,
    output logic        changed
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);

    logic [31:0]   shadow;
    logic [PW-1:0] pcnt;
    logic [2:0]    dig;
    logic          tick;
    logic [31:0]   upper;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    glyph;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    assign tick = (pcnt == PCNT_LAST);

    // Capture the published word unless frozen; flag loads that alter the value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow  <= 32'h0;
            changed <= 1'b0;
        end else if (!freeze) begin
            changed <= (led_output != shadow);
            shadow  <= led_output;
        end else begin
            changed <= 1'b0;
        end
    end

    // Dwell prescaler and digit index; both wrap on the same tick edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt <= '0;
            dig  <= 3'd0;
        end else if (tick) begin
            pcnt <= '0;
            dig  <= dig + 3'd1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Select the active nibble and decide whether it is a leading zero.
    always_comb begin
        upper = shadow >> {dig, 2'b00};
        nib   = upper[3:0];
        blank = blank_lz && (dig != 3'd0) && (upper == 32'h0);
        glyph = blank ? 7'h7F : hex7(nib);
    end

    // Register the pin drivers so nothing reaches the pads combinationally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg <= 7'h7F;
            an  <= 8'hFF;
            dp  <= 1'b1;
        end else begin
            seg <= glyph;
            an  <= ~(8'b1 << dig);
            dp  <= ~(freeze && (dig == 3'd0));
        end
    end

endmodule

// File: tb/tb_g9_led_display.sv
// Bench for g9_led_display: per-cycle comparison against a frame-position model
// plus literal spot checks of the display sequences.
module tb_g9_led_display;

    localparam int SD = 4;
    localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [6:0] LIT2 [8] = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] led_output = 32'h0;
    logic        freeze = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic        dp;
    logic        changed;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_shadow = 32'h0;
    int          e_cnt = 0;

    g9_led_display #(.SCAN_DIV(SD)) dut (
        .clk(clk), .reset(reset), .led_output(led_output), .freeze(freeze),
        .blank_lz(blank_lz), .seg(seg), .an(an), .dp(dp), .changed(changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_an(input logic [7:0] v);
        for (int k = 0; k < 100 && an !== v; k++) @(negedge clk);
        chk("wait_an", {24'h0, an}, {24'h0, v});
    endtask

    // Model: digit position follows from edges since reset release; shadow is the last unfrozen input.
    always @(posedge clk) begin
        logic [6:0]  es;
        logic [7:0]  ea;
        logic        ed, ec;
        int          d;
        logic [31:0] up;
        if (!reset) begin
            es = 7'h7F; ea = 8'hFF; ed = 1'b1; ec = 1'b0;
            e_cnt = 0; m_shadow = 32'h0;
        end else begin
            e_cnt++;
            d  = ((e_cnt - 1) / SD) % 8;
            up = m_shadow >> (4 * d);
            ea = ~(8'd1 << d);
            es = (blank_lz && d != 0 && up == 32'h0) ? 7'h7F : HEX[up[3:0]];
            ed = !(freeze && d == 0);
            ec = !freeze && (led_output != m_shadow);
            if (!freeze) m_shadow = led_output;
        end
        #1;
        chk("m_seg", {25'h0, seg}, {25'h0, es});
        chk("m_an", {24'h0, an}, {24'h0, ea});
        chk("m_dp", {31'h0, dp}, {31'h0, ed});
        chk("m_changed", {31'h0, changed}, {31'h0, ec});
    end

    initial begin
        #1 reset = 1'b0;
        // reset values
        repeat (5) begin
            @(negedge clk);
            chk("rst_an", {24'h0, an}, 32'hFF);
            chk("rst_seg", {25'h0, seg}, 32'h7F);
            chk("rst_dp", {31'h0, dp}, 32'h1);
            chk("rst_chg", {31'h0, changed}, 32'h0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("rel_an", {24'h0, an}, 32'hFE);
        chk("rel_seg", {25'h0, seg}, 32'h40);
        chk("rel_chg", {31'h0, changed}, 32'h0);

        // full hex frame
        led_output = 32'h89AB_CDEF;
        @(negedge clk);
        chk("t2_chg1", {31'h0, changed}, 32'h1);
        @(negedge clk);
        chk("t2_chg0", {31'h0, changed}, 32'h0);
        wait_an(8'h7F);
        wait_an(8'hFE);
        for (int i = 0; i < 8; i++) begin
            chk("t2_seg", {25'h0, seg}, {25'h0, LIT2[i]});
            chk("t2_an", {24'h0, an}, {24'h0, ~(8'd1 << i)});
            repeat (SD) @(negedge clk);
        end

        // leading-zero blanking
        led_output = 32'h0000_00A5;
        blank_lz = 1'b1;
        repeat (3) @(negedge clk);
        wait_an(8'h7F);
        wait_an(8'hFE);
        chk("t3_d0", {25'h0, seg}, 32'h12);
        repeat (SD) @(negedge clk);
        chk("t3_d1", {25'h0, seg}, 32'h08);
        repeat (SD) @(negedge clk);
        chk("t3_d2", {25'h0, seg}, 32'h7F);
        chk("t3_d2an", {24'h0, an}, 32'hFB);
        led_output = 32'h0;
        repeat (3) @(negedge clk);
        wait_an(8'h7F);
        chk("t3_z7", {25'h0, seg}, 32'h7F);
        wait_an(8'hFE);
        chk("t3_z0", {25'h0, seg}, 32'h40);
        repeat (SD) @(negedge clk);
        chk("t3_z1", {25'h0, seg}, 32'h7F);

        // freeze
        blank_lz = 1'b0;
        led_output = 32'h5;
        repeat (3) @(negedge clk);
        freeze = 1'b1;
        @(negedge clk);
        led_output = 32'h7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_nochg", {31'h0, changed}, 32'h0);
        end
        wait_an(8'hFE);
        chk("t4_dp", {31'h0, dp}, 32'h0);
        chk("t4_seg", {25'h0, seg}, 32'h12);
        freeze = 1'b0;
        @(negedge clk);
        chk("t4_chg1", {31'h0, changed}, 32'h1);
        @(negedge clk);
        chk("t4_chg0", {31'h0, changed}, 32'h0);
        wait_an(8'h7F);
        wait_an(8'hFE);
        chk("t4_seg7", {25'h0, seg}, 32'h78);
        chk("t4_dp1", {31'h0, dp}, 32'h1);

        // input changing every cycle
        for (int i = 0; i < 6; i++) begin
            led_output = (i % 2 == 0) ? 32'h1 : 32'h2;
            @(negedge clk);
            chk("t5_chg", {31'h0, changed}, 32'h1);
        end
        @(negedge clk);
        chk("t5_fall", {31'h0, changed}, 32'h0);

        // asynchronous reset mid-frame
        wait_an(8'hDF);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t6_an", {24'h0, an}, 32'hFF);
        chk("t6_seg", {25'h0, seg}, 32'h7F);
        chk("t6_dp", {31'h0, dp}, 32'h1);
        chk("t6_chg", {31'h0, changed}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < SD; i++) begin
            @(negedge clk);
            chk("t6_dwell0", {24'h0, an}, 32'hFE);
        end
        @(negedge clk);
        chk("t6_dig1", {24'h0, an}, 32'hFD);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) != 0)
                led_output = $urandom >> $urandom_range(0, 31);
            freeze   = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
        end
        @(negedge clk);
        freeze = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
